// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared mode encodings, widths and the per-channel
//                configuration record for the LED pattern generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Width of the mode field on the config port
  localparam int LED_MODE_W = 2;

  // Widest period/duty the config record can carry; PER_W must not exceed it
  localparam int LED_MAX_PER_W = 16;

  // Channel output modes
  localparam logic [LED_MODE_W-1:0] LED_OFF     = 2'd0;
  localparam logic [LED_MODE_W-1:0] LED_ON      = 2'd1;
  localparam logic [LED_MODE_W-1:0] LED_PWM     = 2'd2;
  localparam logic [LED_MODE_W-1:0] LED_ONESHOT = 2'd3;

  // One channel's configuration as written through the config port.
  // Period and duty are zero-extended to the package-wide maximum width.
  typedef struct packed {
    logic [LED_MODE_W-1:0]    mode;
    logic [LED_MAX_PER_W-1:0] period;
    logic [LED_MAX_PER_W-1:0] duty;
  } led_cfg_t;

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen_if
//  Description : Valid/ready configuration write port of the LED pattern
//                generator. The register logic is the master, the
//                generator the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int CH_W  = 2,
  parameter int PER_W = 8
);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_ch;
  logic [LED_MODE_W-1:0] cfg_mode;
  logic [PER_W-1:0]      cfg_period;
  logic [PER_W-1:0]      cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_channel
//  Description : One LED channel: config registers, tick-driven phase
//                counter, optional ONESHOT completion and the registered
//                LED output with selectable polarity.
//                Optional feature macro: LED_ONESHOT_EN (ONESHOT mode and
//                the done pulse; without it mode 3 is stored as OFF).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W          = 8,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     wr_en,
  input  led_cfg_t wr_cfg,
  output logic     led,
  output logic     busy,
  output logic     done
);

  logic [LED_MODE_W-1:0]    r_mode;
  logic [LED_MAX_PER_W-1:0] r_period;
  logic [LED_MAX_PER_W-1:0] r_duty;
  logic [PER_W-1:0]         r_phase;
  logic                     r_led;

  logic [LED_MAX_PER_W-1:0] w_phase_ext;
  logic [LED_MODE_W-1:0]    w_wr_mode;
  logic                     w_at_period;
  logic                     w_led_logic;

  assign w_phase_ext = LED_MAX_PER_W'(r_phase);
  assign w_at_period = (w_phase_ext == r_period);

`ifdef LED_ONESHOT_EN
  logic w_at_duty;
  logic r_done;

  assign w_at_duty = (w_phase_ext == r_duty);
  assign w_wr_mode = wr_cfg.mode;
`else
  // Without oneshot support a mode-3 write parks the channel in OFF
  assign w_wr_mode = (wr_cfg.mode == LED_ONESHOT) ? LED_OFF : wr_cfg.mode;
`endif

  // Config load restarts the pattern; otherwise advance phase on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= LED_OFF;
      r_period <= '0;
      r_duty   <= '0;
      r_phase  <= '0;
    end else if (wr_en) begin
      // A write on a tick cycle wins: the tick is dropped for this channel
      r_mode   <= w_wr_mode;
      r_period <= wr_cfg.period;
      r_duty   <= wr_cfg.duty;
      r_phase  <= '0;
    end else if (tick) begin
      case (r_mode)
        LED_PWM: begin
          r_phase <= w_at_period ? '0 : r_phase + PER_W'(1);
        end
`ifdef LED_ONESHOT_EN
        LED_ONESHOT: begin
          if (w_at_duty) begin
            r_mode  <= LED_OFF;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + PER_W'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Logical LED value from the current mode and phase
  always_comb begin
    w_led_logic = 1'b0;
    case (r_mode)
      LED_ON:               w_led_logic = 1'b1;
      LED_PWM, LED_ONESHOT: w_led_logic = (w_phase_ext < r_duty);
      default:              w_led_logic = 1'b0;
    endcase
  end

  // Output register applies the board polarity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= LED_ACTIVE_LOW;
    end else begin
      r_led <= w_led_logic ^ LED_ACTIVE_LOW;
    end
  end

`ifdef LED_ONESHOT_EN
  // One-cycle completion pulse, raised together with the return to OFF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= !wr_en && tick && (r_mode == LED_ONESHOT) && w_at_duty;
    end
  end

  assign done = r_done;
`else
  assign done = 1'b0;
`endif

  assign led  = r_led;
  assign busy = (r_mode == LED_PWM) || (r_mode == LED_ONESHOT);

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Multi-channel LED pattern generator. A shared prescaler
//                produces a tick strobe; config writes are decoded to one
//                of NUM_CH led_channel instances.
//                Optional feature macro: LED_ONESHOT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PRESCALE       = 50000000,
  parameter int PER_W          = 8,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  led_pattern_gen_if.slave    cfg,
  output logic [NUM_CH-1:0]   led,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done,
  output logic                tick
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;
  logic             w_accept;
  led_cfg_t         w_cfg;

  // Ready follows reset directly so no write can land while rst is high
  assign cfg.cfg_ready = ~rst;
  assign w_accept      = cfg.cfg_valid & ~rst;

  assign w_wrap = (r_cnt == CNT_W'(PRESCALE - 1));

  // Prescaler counts 0..PRESCALE-1 and registers a strobe on the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Widen the port fields into the shared config record
  always_comb begin
    w_cfg        = '0;
    w_cfg.mode   = cfg.cfg_mode;
    w_cfg.period = LED_MAX_PER_W'(cfg.cfg_period);
    w_cfg.duty   = LED_MAX_PER_W'(cfg.cfg_duty);
  end

  // Out-of-range channel numbers match no instance and are dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .PER_W          (PER_W),
      .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (r_tick),
      .wr_en  (w_accept && (cfg.cfg_ch == CH_W'(i))),
      .wr_cfg (w_cfg),
      .led    (led[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen (PRESCALE=4).
//                A second instance covers active-low polarity and an
//                out-of-range channel number.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int PS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.CH_W(2), .PER_W(8)) if1 ();
  led_pattern_gen_if #(.CH_W(3), .PER_W(8)) if2 ();

  logic [3:0] led, busy, done;
  logic       tick;
  logic [4:0] led2, busy2, done2;
  logic       tick2;

  led_pattern_gen #(.NUM_CH(4), .PRESCALE(PS), .PER_W(8), .LED_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .cfg(if1), .led(led), .busy(busy), .done(done), .tick(tick)
  );

  led_pattern_gen #(.NUM_CH(5), .PRESCALE(PS), .PER_W(8), .LED_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .cfg(if2), .led(led2), .busy(busy2), .done(done2), .tick(tick2)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_t s;
    s.tag = tag;
    s.val = v;
    sb_q.push_back(s);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t s;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: observed %0h with no expected entry", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.val) else begin
        bad++;
        $error("FAIL %s cyc=%0d: observed %0h expected %0h", s.tag, cyc, obs, s.val);
      end
    end
  endtask

  // Reference LED for a P/D PWM pattern loaded on a tick edge 'acc'
  function automatic logic led_exp(input int acc, input int e, input int p, input int d);
    int n;
    n = (e - 1 - acc) / PS;
    return (n % (p + 1)) < d;
  endfunction

  // Advance until the coming edge is a tick edge (bounded)
  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 2 * PS) begin
      step();
      n++;
    end
    sb_push("tick_wait", 32'd1);
    sb_check(32'(tick));
  endtask

  task automatic write1(input int ch, input int mode, input int p, input int d);
    if1.cfg_ch     = 2'(ch);
    if1.cfg_mode   = 2'(mode);
    if1.cfg_period = 8'(p);
    if1.cfg_duty   = 8'(d);
    if1.cfg_valid  = 1'b1;
    sb_push("ready1", 32'd1);
    sb_check(32'(if1.cfg_ready));
    step();
    if1.cfg_valid = 1'b0;
  endtask

  task automatic write2(input int ch, input int mode, input int p, input int d);
    if2.cfg_ch     = 3'(ch);
    if2.cfg_mode   = 2'(mode);
    if2.cfg_period = 8'(p);
    if2.cfg_duty   = 8'(d);
    if2.cfg_valid  = 1'b1;
    step();
    if2.cfg_valid = 1'b0;
  endtask

  initial begin
    int   a0, a2, b;
    logic l0, l2, b2, d2;

    if1.cfg_valid = 1'b0; if1.cfg_ch = '0; if1.cfg_mode = '0; if1.cfg_period = '0; if1.cfg_duty = '0;
    if2.cfg_valid = 1'b0; if2.cfg_ch = '0; if2.cfg_mode = '0; if2.cfg_period = '0; if2.cfg_duty = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    sb_push("rst_led", 32'h0);   sb_check(32'(led));
    sb_push("rst_busy", 32'h0);  sb_check(32'(busy));
    sb_push("rst_done", 32'h0);  sb_check(32'(done));
    sb_push("rst_tick", 32'h0);  sb_check(32'(tick));
    sb_push("rst_ready", 32'h0); sb_check(32'(if1.cfg_ready));
    sb_push("rst_led_al", 32'h1f); sb_check(32'(led2));

    // Release and watch the prescaler: ticks at cycles 4, 8, 12
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      sb_push("tick_seq", 32'(i % PS == 0));
      sb_check(32'(tick));
    end
    sb_push("idle_led", 32'h0);  sb_check(32'(led));
    sb_push("idle_busy", 32'h0); sb_check(32'(busy));

    // ch0 PWM P=3 D=2, accepted on a tick edge: 8 high / 8 low
    wait_tick();
    write1(0, LED_PWM, 3, 2);
    a0 = cyc;
    sb_push("pwm0_busy", 32'h1); sb_check(32'(busy));
    for (int i = 1; i <= 32; i++) begin
      step();
      sb_push("pwm0_led", 32'(led_exp(a0, cyc, 3, 2)));
      sb_check(32'(led[0]));
    end

    // ch1 ON, ch2 PWM D=0, ch3 PWM P=2 D=5: constant outputs
    write1(1, LED_ON, 0, 0);
    write1(2, LED_PWM, 3, 0);
    write1(3, LED_PWM, 2, 5);
    for (int i = 1; i <= 12; i++) begin
      step();
      sb_push("const_led", 32'({1'b1, 1'b0, 1'b1, led_exp(a0, cyc, 3, 2)}));
      sb_check(32'(led));
      sb_push("const_busy", 32'h0d);
      sb_check(32'(busy));
    end

    // ch2 ONESHOT D=3 on a tick edge
    wait_tick();
    write1(2, LED_ONESHOT, 0, 3);
    a2 = cyc;
    for (int i = 1; i <= 20; i++) begin
      step();
`ifdef LED_ONESHOT_EN
      l2 = (i <= 12);
      b2 = (i < 16);
      d2 = (i == 16);
`else
      l2 = 1'b0;
      b2 = 1'b0;
      d2 = 1'b0;
`endif
      sb_push("os_led", 32'({1'b1, l2, 1'b1, led_exp(a0, cyc, 3, 2)}));
      sb_check(32'(led));
      sb_push("os_busy", 32'({1'b1, b2, 1'b0, 1'b1}));
      sb_check(32'(busy));
      sb_push("os_done", 32'({1'b0, d2, 2'b00}));
      sb_check(32'(done));
    end
    if (a2 < 0) $display("unreachable");

    // ch1 PWM, then rewrite ch0 on a later tick edge: ch0 restarts, ch1 runs on
    wait_tick();
    write1(1, LED_PWM, 3, 2);
    b = cyc;
    for (int i = 1; i <= 24; i++) begin
      if (i == 4) begin
        sb_push("tick_collide", 32'd1);
        sb_check(32'(tick));
        if1.cfg_ch = 2'd0; if1.cfg_mode = LED_PWM; if1.cfg_period = 8'd3; if1.cfg_duty = 8'd2;
        if1.cfg_valid = 1'b1;
      end
      step();
      if1.cfg_valid = 1'b0;
      l0 = (i <= 4) ? led_exp(a0, cyc, 3, 2) : led_exp(b + 4, cyc, 3, 2);
      sb_push("rewrite_led", 32'({1'b1, 1'b0, led_exp(b, cyc, 3, 2), l0}));
      sb_check(32'(led));
    end

    // Asynchronous reset mid-pattern, held across one edge
    #3;
    rst = 1'b1;
    #1;
    sb_push("arst_led", 32'h0);   sb_check(32'(led));
    sb_push("arst_busy", 32'h0);  sb_check(32'(busy));
    sb_push("arst_done", 32'h0);  sb_check(32'(done));
    sb_push("arst_tick", 32'h0);  sb_check(32'(tick));
    sb_push("arst_ready", 32'h0); sb_check(32'(if1.cfg_ready));
    sb_push("arst_led_al", 32'h1f); sb_check(32'(led2));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      sb_push("tick_restart", 32'(i % PS == 0));
      sb_check(32'(tick));
    end
    sb_push("post_led", 32'h0);  sb_check(32'(led));
    sb_push("post_busy", 32'h0); sb_check(32'(busy));

    // Active-low instance: out-of-range channel ignored, valid writes inverted
    write2(5, LED_ON, 0, 0);
    step();
    sb_push("al_oor_led", 32'h1f);  sb_check(32'(led2));
    sb_push("al_oor_busy", 32'h0);  sb_check(32'(busy2));
    write2(4, LED_ON, 0, 0);
    step();
    sb_push("al_on_led", 32'h0f);   sb_check(32'(led2));
    write2(0, LED_PWM, 0, 1);
    step();
    sb_push("al_pwm_led", 32'h0e);  sb_check(32'(led2));
    sb_push("al_pwm_busy", 32'h01); sb_check(32'(busy2));
    sb_push("al_done", 32'h0);      sb_check(32'(done2 | {4'b0, tick2 & 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
